// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl
//   Initiator for a single-ported synchronous SRAM (one RW port, 1-cycle read
//   latency, lane-masked write). Turns a valid/ready request stream into
//   RW-port strobes and returns read data on a valid/ready response stream.
//   Read data is only valid in the cycle after its strobe, so it is either
//   handed straight to the consumer (bypass) or parked in a small FIFO.
//
// Ports
//   clock, reset_n          clock, async active-low reset
//   req_valid/req_ready     request handshake
//   req_write               1 = masked write, 0 = read
//   req_addr/wdata/wmask    request payload
//   resp_valid/resp_ready   read-response handshake
//   resp_data               read data, in request order
//   sram_en/wmode/addr/
//   sram_wmask/wdata        RW-port strobes (driven to 0 when idle)
//   sram_rdata              RW-port read data
module sram_rw_port_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BITS  = 128,
  parameter int MASK_BITS  = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  input  logic [MASK_BITS-1:0] req_wmask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 sram_en,
  output logic                 sram_wmode,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [MASK_BITS-1:0] sram_wmask,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic                 inflight;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [DATA_BITS-1:0] fifo_mem [RESP_DEPTH];

  logic [OCC_W-1:0]     occupancy;
  logic                 fifo_empty;
  logic                 accept;
  logic                 pop;
  logic                 push;
  logic                 fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read in flight already owns a FIFO slot, so credits count it too.
  // This keeps the push below from ever overflowing.
  assign occupancy  = OCC_W'(count) + OCC_W'(inflight);
  assign req_ready  = reset_n && (occupancy < OCC_W'(RESP_DEPTH));
  assign accept     = req_valid && req_ready;

  assign sram_en    = accept;
  assign sram_wmode = accept ? req_write : 1'b0;
  assign sram_addr  = accept ? req_addr  : '0;
  assign sram_wmask = accept ? req_wmask : '0;
  assign sram_wdata = accept ? req_wdata : '0;

  assign fifo_empty = (count == '0);
  assign resp_valid = !fifo_empty || inflight;
  assign resp_data  = fifo_empty ? sram_rdata : fifo_mem[rd_ptr];
  assign pop        = resp_valid && resp_ready;

  // With an empty FIFO a pop consumes the bypassed read data directly;
  // otherwise the fresh read result must be parked behind older entries.
  assign push       = inflight && !(fifo_empty && pop);
  assign fifo_pop   = pop && !fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= accept && !req_write;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; entries are only read once counted.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= sram_rdata;
  end

  a_credit_inv: assert property (@(posedge clock) disable iff (!reset_n)
    occupancy <= OCC_W'(RESP_DEPTH));

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: SRAM macro model, reference memory and an
// expected-response queue; directed phases followed by a randomized phase.
module tb_sram_rw_port_ctrl;
  localparam int AW = 10;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int RD = 2;
  localparam int LW = DW / MW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  logic rr_fixed = 1'b1;
  logic rr_rand  = 1'b0;
  logic rand_rr  = 1'b0;
  assign resp_ready = rand_rr ? rr_rand : rr_fixed;

  always #5 clock = ~clock;

  sram_rw_port_ctrl #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .MASK_BITS(MW), .RESP_DEPTH(RD)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_w;
    for (int l = 0; l < MW; l++)
      if (m[l]) r[l*LW +: LW] = new_w[l*LW +: LW];
    return r;
  endfunction

  // SRAM macro model: read data valid only the cycle after a read strobe,
  // random garbage otherwise.
  logic [DW-1:0] ref_mem  [1 << AW];
  logic [DW-1:0] sram_mem [1 << AW];
  logic          sram_init_done = 1'b0;

  always @(posedge clock) begin
    if (!sram_init_done) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= ref_mem[i];
      sram_init_done <= 1'b1;
    end else if (sram_en && sram_wmode) begin
      sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_wmask);
    end
    if (sram_en && !sram_wmode) sram_rdata <= sram_mem[sram_addr];
    else sram_rdata <= rnd128();
  end

  always @(posedge clock) begin
    #1;
    rr_rand = $urandom_range(0, 1) == 1;
  end

  // Reference: every accepted read expects the latest written word, and
  // responses come back in acceptance order.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            pop_cnt = 0;
  logic          chk_lat = 1'b0;
  logic          mon_rdy;
  logic [DW-1:0] last_resp = '0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset_n) begin
      mon_rdy = exp_q.size() < RD;
      check_val("req_ready", DW'(req_ready), DW'(mon_rdy));
      check_val("resp_valid", DW'(resp_valid), DW'(exp_q.size() > 0));
      check_val("sram_en", DW'(sram_en), DW'(req_valid && mon_rdy));
      if (resp_valid && resp_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_val("resp_data", resp_data, mon_e.data);
        if (chk_lat) check_val("resp_latency", DW'(cyc - mon_e.cyc), DW'(1));
        last_resp = resp_data;
        pop_cnt++;
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        check_val("sram_addr", DW'(sram_addr), DW'(req_addr));
        check_val("sram_wmode", DW'(sram_wmode), DW'(req_write));
        if (req_write) begin
          check_val("sram_wdata", sram_wdata, req_wdata);
          check_val("sram_wmask", DW'(sram_wmask), DW'(req_wmask));
          ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
        end else begin
          mon_e.data = ref_mem[req_addr];
          mon_e.cyc  = cyc;
          exp_q.push_back(mon_e);
        end
      end
    end
  end

  // Called at posedge+1 with req_valid already high.
  task automatic wait_accept(output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      waited++;
      if (req_ready) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    if (!ok) check_val("accept_timeout", DW'(0), DW'(1));
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m,
                        output int waited);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    req_valid = 1'b1;
    wait_accept(waited);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (exp_q.size() > 0) check_val("drain_timeout", DW'(exp_q.size()), DW'(0));
  endtask

  localparam logic [DW-1:0] C1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    int w, tot, a0, p0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = rnd128();

    // Reset held with a request pending
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd3;
    req_wdata = '0;   req_wmask = '0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_req_ready", DW'(req_ready), DW'(0));
    check_val("rst_sram_en", DW'(sram_en), DW'(0));
    check_val("rst_resp_valid", DW'(resp_valid), DW'(0));
    req_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check_val("rel_req_ready", DW'(req_ready), DW'(1));
    @(posedge clock);
    #1;

    // Directed write / read / masked writes
    chk_lat = 1'b1;
    do_req(1'b1, 10'h005, C1, 16'hFFFF, w);
    do_req(1'b0, 10'h005, '0, '0, w);
    drain();
    check_val("wr_rd_data", last_resp, C1);
    do_req(1'b1, 10'h005, {DW{1'b1}}, 16'h0001, w);
    do_req(1'b0, 10'h005, '0, '0, w);
    drain();
    check_val("mask_lo_data", last_resp, C1);
    do_req(1'b1, 10'h005, '0, 16'h0100, w);
    do_req(1'b0, 10'h005, '0, '0, w);
    drain();
    check_val("mask_b8_data", last_resp, 128'h00112233_44556600_8899AABB_CCDDEEFF);

    // Streaming: 16 back-to-back reads
    tot = 0;
    p0 = pop_cnt;
    for (int a = 0; a < 16; a++) begin
      do_req(1'b0, AW'(a), '0, '0, w);
      tot += w;
    end
    drain();
    check_val("stream_cycles", DW'(tot), DW'(16));
    check_val("stream_resps", DW'(pop_cnt - p0), DW'(16));

    // Backpressure: only RESP_DEPTH reads accepted while stalled
    chk_lat = 1'b0;
    rr_fixed = 1'b0;
    a0 = acc_cnt;
    p0 = pop_cnt;
    do_req(1'b0, 10'd20, '0, '0, w);
    do_req(1'b0, 10'd21, '0, '0, w);
    req_write = 1'b0; req_addr = 10'd22; req_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_val("bp_accepted", DW'(acc_cnt - a0), DW'(2));
    check_val("bp_ready", DW'(req_ready), DW'(0));
    check_val("bp_resp_valid", DW'(resp_valid), DW'(1));
    rr_fixed = 1'b1;
    wait_accept(w);
    do_req(1'b0, 10'd23, '0, '0, w);
    drain();
    check_val("bp_returned", DW'(pop_cnt - p0), DW'(4));
    check_val("bp_accepted_all", DW'(acc_cnt - a0), DW'(4));

    // Randomized traffic with random response backpressure
    rand_rr = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      do_req($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), rnd128(),
             MW'($urandom()), w);
    end
    drain();
    rand_rr = 1'b0;
    rr_fixed = 1'b1;
    @(posedge clock);
    #1;

    // Async reset with one buffered and one in-flight read
    rr_fixed = 1'b0;
    do_req(1'b0, 10'd1, '0, '0, w);
    do_req(1'b0, 10'd2, '0, '0, w);
    check_val("pre_rst_valid", DW'(resp_valid), DW'(1));
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_resp_valid", DW'(resp_valid), DW'(0));
    check_val("mid_rst_req_ready", DW'(req_ready), DW'(0));
    check_val("mid_rst_sram_en", DW'(sram_en), DW'(0));
    exp_q.delete();
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    rr_fixed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check_val("stale_resp", DW'(resp_valid), DW'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
